// File: rtl/fpu_add_arbiter.sv
// Two-requester round-robin front end for a shared FP adder/subtractor.
// Grants one requester, drives the FPU, times out stalled operations, and returns a registered result.
module fpu_add_arbiter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_0,
  input  logic         req_1,
  input  logic [W-1:0] x_0,
  input  logic [W-1:0] y_0,
  input  logic [W-1:0] x_1,
  input  logic [W-1:0] y_1,
  input  logic         op_0,
  input  logic         op_1,
  input  logic [1:0]   r_mode_cfg,
  output logic         gnt_0,
  output logic         gnt_1,
  output logic         done_0,
  output logic         done_1,
  output logic [W-1:0] res_data,
  output logic         res_ovf,
  output logic         res_unf,
  output logic         res_err,
  output logic         fpu_beg,
  output logic         fpu_rst_fsm,
  output logic [W-1:0] fpu_data_x,
  output logic [W-1:0] fpu_data_y,
  output logic         fpu_add_subt,
  output logic [1:0]   fpu_r_mode,
  input  logic         fpu_ready,
  input  logic [W-1:0] fpu_result,
  input  logic         fpu_ovf,
  input  logic         fpu_unf
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW:0] CNT_LAST = (CW + 1)'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, ABORT, CLEAR} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic           done0_q, done0_d, done1_q, done1_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic           res_ovf_q, res_ovf_d, res_unf_q, res_unf_d, res_err_q, res_err_d;
  logic           beg_q, beg_d, rst_fsm_q, rst_fsm_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic           op_q, op_d;
  logic [1:0]     rm_q, rm_d;
  logic           win;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    res_unf_d  = res_unf_q;
    res_err_d  = res_err_q;
    beg_d      = 1'b0;
    rst_fsm_d  = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    op_d       = op_q;
    rm_d       = rm_q;
    win        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_0 || req_1) begin
          // win=1 selects requester 1; on contention the one not served last wins
          win     = (req_0 && req_1) ? ~last_q : req_1;
          gnt0_d  = ~win;
          gnt1_d  = win;
          x_d     = win ? x_1 : x_0;
          y_d     = win ? y_1 : y_0;
          op_d    = win ? op_1 : op_0;
          rm_d    = r_mode_cfg;
          beg_d   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fpu_ready) begin
          res_data_d = fpu_result;
          res_ovf_d  = fpu_ovf;
          res_unf_d  = fpu_unf;
          res_err_d  = 1'b0;
          done0_d    = gnt0_q;
          done1_d    = gnt1_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // counter includes the current WAIT cycle once incremented
          if (({1'b0, cnt_q} + 1'b1) == CNT_LAST) begin
            state_d = ABORT;
          end
        end
      end
      ABORT: begin
        res_data_d = '0;
        res_ovf_d  = 1'b0;
        res_unf_d  = 1'b0;
        res_err_d  = 1'b1;
        done0_d    = gnt0_q;
        done1_d    = gnt1_q;
        state_d    = DONE;
      end
      DONE: begin
        last_d    = gnt1_q;
        rst_fsm_d = 1'b1;
        state_d   = CLEAR;
      end
      CLEAR: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      res_unf_q  <= 1'b0;
      res_err_q  <= 1'b0;
      beg_q      <= 1'b0;
      rst_fsm_q  <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= 1'b0;
      rm_q       <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      res_unf_q  <= res_unf_d;
      res_err_q  <= res_err_d;
      beg_q      <= beg_d;
      rst_fsm_q  <= rst_fsm_d;
      x_q        <= x_d;
      y_q        <= y_d;
      op_q       <= op_d;
      rm_q       <= rm_d;
    end
  end

  assign gnt_0        = gnt0_q;
  assign gnt_1        = gnt1_q;
  assign done_0       = done0_q;
  assign done_1       = done1_q;
  assign res_data     = res_data_q;
  assign res_ovf      = res_ovf_q;
  assign res_unf      = res_unf_q;
  assign res_err      = res_err_q;
  assign fpu_beg      = beg_q;
  assign fpu_rst_fsm  = rst_fsm_q;
  assign fpu_data_x   = x_q;
  assign fpu_data_y   = y_q;
  assign fpu_add_subt = op_q;
  assign fpu_r_mode   = rm_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: transaction-timeline model plus directed scenarios.
module tb_fpu_add_arbiter;
  localparam int W  = 32;
  localparam int TO = 63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         req_0 = 0, req_1 = 0, op_0 = 0, op_1 = 0;
  logic [W-1:0] x_0 = 0, y_0 = 0, x_1 = 0, y_1 = 0;
  logic [1:0]   r_mode_cfg = 0;
  logic         gnt_0, gnt_1, done_0, done_1, res_ovf, res_unf, res_err;
  logic [W-1:0] res_data, fpu_data_x, fpu_data_y;
  logic         fpu_beg, fpu_rst_fsm, fpu_add_subt;
  logic [1:0]   fpu_r_mode;
  logic         fpu_ready;
  logic         resp_ready = 0, idle_ready = 0;
  logic [W-1:0] fpu_result = 0;
  logic         fpu_ovf = 0, fpu_unf = 0;

  assign fpu_ready = resp_ready | idle_ready;

  fpu_add_arbiter #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .req_1(req_1),
    .x_0(x_0), .y_0(y_0), .x_1(x_1), .y_1(y_1),
    .op_0(op_0), .op_1(op_1), .r_mode_cfg(r_mode_cfg),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
    .res_data(res_data), .res_ovf(res_ovf), .res_unf(res_unf), .res_err(res_err),
    .fpu_beg(fpu_beg), .fpu_rst_fsm(fpu_rst_fsm),
    .fpu_data_x(fpu_data_x), .fpu_data_y(fpu_data_y),
    .fpu_add_subt(fpu_add_subt), .fpu_r_mode(fpu_r_mode),
    .fpu_ready(fpu_ready), .fpu_result(fpu_result), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // FPU stand-in: raises ready in the dly-th WAIT cycle after a start pulse (dly=0: never)
  int           dly = 0;
  logic [W-1:0] rval = 0;
  logic         rovf = 0, runf = 0;
  always begin
    @(negedge clk);
    if (fpu_beg && dly != 0) begin
      repeat (dly) @(posedge clk);
      #1;
      resp_ready = 1'b1; fpu_result = rval; fpu_ovf = rovf; fpu_unf = runf;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
  end

  // Model: age counts cycles since grant (1 = start cycle), fin = age of the done cycle
  bit           m_on = 0, m_owner = 0, m_last = 1, e_rstf = 0;
  int           age = 0, fin = 0;
  logic [W-1:0] e_x = 0, e_y = 0, e_res = 0, p_res = 0;
  logic         e_op = 0, e_ovf = 0, e_unf = 0, e_err = 0, p_ovf = 0, p_unf = 0, p_err = 0;
  logic [1:0]   e_rm = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1; age = 0; fin = 0; m_last = 1; m_owner = 0;
      e_x = 0; e_y = 0; e_op = 0; e_rm = 0; e_res = 0; e_ovf = 0; e_unf = 0; e_err = 0;
      e_rstf = 1;
    end else if (m_on) begin
      if (age == 0) begin
        if (req_0 || req_1) begin
          m_owner = (req_0 && req_1) ? !m_last : req_1;
          e_x  = m_owner ? x_1 : x_0;
          e_y  = m_owner ? y_1 : y_0;
          e_op = m_owner ? op_1 : op_0;
          e_rm = r_mode_cfg;
          age = 1; fin = 0;
        end
      end else begin
        if (fin == 0 && age >= 2) begin
          if (fpu_ready) begin
            fin = age + 1; p_res = fpu_result; p_ovf = fpu_ovf; p_unf = fpu_unf; p_err = 0;
          end else if (age - 1 == TO) begin
            fin = age + 2; p_res = 0; p_ovf = 0; p_unf = 0; p_err = 1;
          end
        end
        if (fin != 0 && age == fin + 1) age = 0;
        else age = age + 1;
        if (fin != 0 && age == fin) begin
          e_res = p_res; e_ovf = p_ovf; e_unf = p_unf; e_err = p_err; m_last = m_owner;
        end
      end
      e_rstf = (fin != 0 && age == fin + 1);
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (m_on) begin
      check("outputs",
        {51'd0, gnt_0, gnt_1, done_0, done_1, fpu_beg, fpu_rst_fsm, fpu_add_subt, fpu_r_mode,
         res_ovf, res_unf, res_err},
        {51'd0, age != 0 && !m_owner, age != 0 && m_owner,
         fin != 0 && age == fin && !m_owner, fin != 0 && age == fin && m_owner,
         age == 1, e_rstf, e_op, e_rm, e_ovf, e_unf, e_err});
      check("data", {res_data, fpu_data_x}, {e_res, e_x});
      check("data_y", {32'd0, fpu_data_y}, {32'd0, e_y});
      check("excl", {62'd0, gnt_0 & gnt_1, done_0 & done_1}, 64'd0);
    end
  end

  int beg_cyc = 0, d_cyc = 0, n_done = 0, n_gnt = 0;
  always @(negedge clk) begin
    if (fpu_beg) beg_cyc = cyc;
    if (done_0 || done_1) n_done++;
    if (gnt_0 || gnt_1) n_gnt++;
  end

  task automatic wait_done(input string nm, output int who);
    who = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_0 || done_1) begin
        who = done_1 ? 1 : 0;
        d_cyc = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s: no done within 200 cycles", nm);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  int who;
  int order[3];
  int prev;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_fsm_in_reset", fpu_rst_fsm, 1);
    check("gnt_in_reset", {gnt_0, gnt_1}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_fsm_released", fpu_rst_fsm, 0);

    // Single add from requester 0
    x_0 = 32'h40066666; y_0 = 32'h40466666; op_0 = 0; r_mode_cfg = 2'b01;
    dly = 10; rval = 32'h40A66666; rovf = 0; runf = 0;
    req_0 = 1;
    @(negedge clk); @(negedge clk);
    check("x_latched", fpu_data_x, 32'h40066666);
    check("rmode_latched", fpu_r_mode, 2'b01);
    wait_done("t1_done", who);
    check("t1_who", who, 0);
    check("t1_res", res_data, 32'h40A66666);
    check("t1_err", res_err, 0);
    check("t1_latency", d_cyc - beg_cyc, 11);
    @(negedge clk);
    check("t1_rst_fsm_pulse", fpu_rst_fsm, 1);
    req_0 = 0;
    repeat (4) @(negedge clk);

    // Both requesting from reset: round-robin 0,1,0 with 3-cycle gap
    do_reset();
    x_1 = 32'h3F800000; y_1 = 32'h40000000; op_1 = 1; dly = 3; rval = 32'hBF800000;
    req_0 = 1; req_1 = 1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_done("t2_done", who);
      order[k] = who;
      if (k > 0) check("t2_gap", beg_cyc - prev, 3);
      prev = d_cyc;
    end
    req_0 = 0; req_1 = 0;
    check("t2_order", {order[0][7:0], order[1][7:0], order[2][7:0]}, 24'h000100);
    repeat (4) @(negedge clk);

    // Timeout abort, then a normal operation
    dly = 0; req_1 = 1;
    wait_done("t3_done", who);
    check("t3_who", who, 1);
    check("t3_err", res_err, 1);
    check("t3_res", res_data, 0);
    check("t3_latency", d_cyc - beg_cyc, 65);
    @(negedge clk);
    req_1 = 0;
    dly = 2; rval = 32'hC0000000; runf = 1;
    req_0 = 1;
    wait_done("t3b_done", who);
    check("t3b_err", res_err, 0);
    check("t3b_res", {res_unf, res_data}, {1'b1, 32'hC0000000});
    check("t3b_latency", d_cyc - beg_cyc, 3);
    @(negedge clk);
    req_0 = 0; runf = 0;
    repeat (3) @(negedge clk);

    // Ready coincident with the last allowed WAIT cycle
    dly = 63; rval = 32'h3F800000; rovf = 1;
    req_0 = 1;
    wait_done("t4_done", who);
    check("t4_err", res_err, 0);
    check("t4_res", {res_ovf, res_data}, {1'b1, 32'h3F800000});
    check("t4_latency", d_cyc - beg_cyc, 64);
    @(negedge clk);
    req_0 = 0; rovf = 0;
    repeat (3) @(negedge clk);

    // Ready held in IDLE with no request
    n_done = 0; n_gnt = 0;
    idle_ready = 1;
    repeat (10) @(negedge clk);
    idle_ready = 0;
    check("t5_no_activity", {n_gnt[15:0], n_done[15:0]}, 0);

    // Reset during WAIT
    dly = 0; req_1 = 1;
    for (int i = 0; i < 10 && !fpu_beg; i++) @(negedge clk);
    check("t6_beg_seen", fpu_beg, 1);
    repeat (5) @(negedge clk);
    rst = 1; req_1 = 0;
    @(negedge clk);
    check("t6_after_rst", {gnt_0, gnt_1, done_0, done_1, fpu_rst_fsm, fpu_beg}, 6'b000010);
    check("t6_data_cleared", {res_data, fpu_data_x}, 0);
    rst = 0;
    n_done = 0;
    repeat (80) @(negedge clk);
    check("t6_no_done", n_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
